// File: rtl/dvga_mix_pkg.sv
// dvga_mix_pkg: shared constants and types for the dvga pixel mixer.
// Optional blending is enabled by DVGA_MIX_BLEND_EN.
package dvga_mix_pkg;

  localparam int CTRL_OUTEN  = 0;
  localparam int CTRL_HINV   = 1;
  localparam int CTRL_VINV   = 2;
  localparam int CTRL_BINV   = 3;
  localparam int FRAME_CNT_W = 16;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } timing_t;

endpackage

// File: rtl/dvga_mix_stage.sv
// dvga_mix_stage: one registered overlay layer (replace or, with
// DVGA_MIX_BLEND_EN, average with the incoming pixel).
module dvga_mix_stage
  import dvga_mix_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3*CW-1:0] pix_i,
  input  timing_t         tim_i,
  input  logic [3*CW-1:0] lay_rgb_i,
  input  logic            lay_opaque_i,
  input  logic            lay_en_i,
`ifdef DVGA_MIX_BLEND_EN
  input  logic            blend_i,
`endif
  output logic [3*CW-1:0] pix_o,
  output timing_t         tim_o
);

  logic            hit;
  logic [3*CW-1:0] nxt;

  assign hit = lay_en_i && lay_opaque_i;

`ifdef DVGA_MIX_BLEND_EN
  logic [3*CW-1:0] mix;
  logic [2:0]      lsb_unused;

  // Sum in CW+1 bits, drop the LSB to floor-halve.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign {mix[c*CW +: CW], lsb_unused[c]} =
      {1'b0, pix_i[c*CW +: CW]} +
      {1'b0, lay_rgb_i[c*CW +: CW]};
  end
`endif

  always_comb begin
    nxt = pix_i;
    unique case (1'b1)
`ifdef DVGA_MIX_BLEND_EN
      hit &&  blend_i: nxt = mix;
      hit && !blend_i: nxt = lay_rgb_i;
`else
      hit:             nxt = lay_rgb_i;
`endif
      default:         nxt = pix_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_o <= '0;
      tim_o <= '0;
    end else begin
      pix_o <= nxt;
      tim_o <= tim_i;
    end
  end

endmodule

// File: rtl/dvga_mixer.sv
// dvga_mixer: N-layer priority compositor, pad stage and frame irq.
// Optional per-layer blending is enabled by DVGA_MIX_BLEND_EN.
module dvga_mixer
  import dvga_mix_pkg::*;
#(
  parameter int NLAYERS = 2,
  parameter int CW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CW-1:0]           r_i,
  input  logic [CW-1:0]           g_i,
  input  logic [CW-1:0]           b_i,
  input  logic                    hsync_i,
  input  logic                    vsync_i,
  input  logic                    blank_i,
  input  logic [NLAYERS*3*CW-1:0] lay_rgb_i,
  input  logic [NLAYERS-1:0]      lay_opaque_i,
  input  logic [NLAYERS-1:0]      lay_en_i,
  input  logic [NLAYERS-1:0]      blend_i,
  input  logic [3:0]              ctrl_i,
  input  logic                    int_clr_i,
  output logic [CW-1:0]           r_pad_o,
  output logic [CW-1:0]           g_pad_o,
  output logic [CW-1:0]           b_pad_o,
  output logic                    hsync_pad_o,
  output logic                    vsync_pad_o,
  output logic                    blank_pad_o,
  output logic                    int_o,
  output logic [FRAME_CNT_W-1:0]  frame_cnt_o
);

  localparam int PW = 3 * CW;
`ifdef DVGA_MIX_BLEND_EN
  localparam int LW = PW + 3;
`else
  localparam int LW = PW + 2;
`endif

  logic [PW-1:0] pix_in;
  timing_t       tim_in;
  logic [LW-1:0] lay_q [NLAYERS];
  logic [PW-1:0] pix_s [NLAYERS];
  timing_t       tim_s [NLAYERS];

`ifndef DVGA_MIX_BLEND_EN
  logic blend_unused;
  assign blend_unused = ^blend_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_in <= '0;
      tim_in <= '0;
      for (int k = 0; k < NLAYERS; k++)
        lay_q[k] <= '0;
    end else begin
      pix_in <= {r_i, g_i, b_i};
      tim_in <= '{hsync_i, vsync_i, blank_i};
      for (int k = 0; k < NLAYERS; k++)
`ifdef DVGA_MIX_BLEND_EN
        lay_q[k] <= {blend_i[k], lay_en_i[k],
                     lay_opaque_i[k],
                     lay_rgb_i[k*PW +: PW]};
`else
        lay_q[k] <= {lay_en_i[k], lay_opaque_i[k],
                     lay_rgb_i[k*PW +: PW]};
`endif
    end
  end

  for (genvar k = 0; k < NLAYERS; k++) begin : g_lay
    logic [LW-1:0] lay_d;
    logic [PW-1:0] p_in;
    timing_t       t_in;

    // Layer k data waits k cycles to meet its pixel at stage k.
    if (k == 0) begin : g_now
      assign lay_d = lay_q[0];
      assign p_in  = pix_in;
      assign t_in  = tim_in;
    end else begin : g_dly
      logic [k-1:0][LW-1:0] sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr[0] <= lay_q[k];
          for (int j = 1; j < k; j++)
            sr[j] <= sr[j-1];
        end
      end
      assign lay_d = sr[k-1];
      assign p_in  = pix_s[k-1];
      assign t_in  = tim_s[k-1];
    end

    dvga_mix_stage #(
      .CW(CW)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .pix_i       (p_in),
      .tim_i       (t_in),
      .lay_rgb_i   (lay_d[PW-1:0]),
      .lay_opaque_i(lay_d[PW]),
      .lay_en_i    (lay_d[PW+1]),
`ifdef DVGA_MIX_BLEND_EN
      .blend_i     (lay_d[PW+2]),
`endif
      .pix_o       (pix_s[k]),
      .tim_o       (tim_s[k])
    );
  end

  logic [PW-1:0]          pix_l;
  timing_t                tim_l;
  logic                   outen;
  logic                   vs_prev;
  logic                   frame_ev;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  assign pix_l    = pix_s[NLAYERS-1];
  assign tim_l    = tim_s[NLAYERS-1];
  assign outen    = ctrl_i[CTRL_OUTEN];
  assign frame_ev = tim_l.vsync && !vs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_pad_o, g_pad_o, b_pad_o} <= '0;
      hsync_pad_o <= 1'b0;
      vsync_pad_o <= 1'b0;
      blank_pad_o <= 1'b0;
    end else begin
      {r_pad_o, g_pad_o, b_pad_o} <=
        (outen && !tim_l.blank) ? pix_l : '0;
      hsync_pad_o <= outen &&
                     (ctrl_i[CTRL_HINV] ^ tim_l.hsync);
      vsync_pad_o <= outen &&
                     (ctrl_i[CTRL_VINV] ^ tim_l.vsync);
      blank_pad_o <= outen &&
                     (ctrl_i[CTRL_BINV] ^ tim_l.blank);
    end
  end

  // Frame events ignore outen; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev     <= 1'b0;
      int_o       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_prev <= tim_l.vsync;
      if (frame_ev) begin
        int_o       <= 1'b1;
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end else if (int_clr_i) begin
        int_o <= 1'b0;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_dvga_mixer.sv
// tb_dvga_mixer: directed stimulus, per-cycle reference model
// and literal spot checks for dvga_mixer.
module tb_dvga_mixer;

  localparam int NL = 2;
  localparam int CW = 8;
  localparam int PW = 3 * CW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CW-1:0]   r = '0, g = '0, b = '0;
  logic            hs = 1'b0, vs = 1'b0, bl = 1'b0;
  logic [NL*PW-1:0] lay_rgb = '0;
  logic [NL-1:0]   lay_op = '0, lay_en = '0, blend = '0;
  logic [3:0]      ctrl = 4'h0;
  logic            int_clr = 1'b0;

  logic [CW-1:0]   r_pad, g_pad, b_pad;
  logic            hs_pad, vs_pad, bl_pad;
  logic            irq;
  logic [15:0]     cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dvga_mixer #(
    .NLAYERS(NL),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .r_i         (r),
    .g_i         (g),
    .b_i         (b),
    .hsync_i     (hs),
    .vsync_i     (vs),
    .blank_i     (bl),
    .lay_rgb_i   (lay_rgb),
    .lay_opaque_i(lay_op),
    .lay_en_i    (lay_en),
    .blend_i     (blend),
    .ctrl_i      (ctrl),
    .int_clr_i   (int_clr),
    .r_pad_o     (r_pad),
    .g_pad_o     (g_pad),
    .b_pad_o     (b_pad),
    .hsync_pad_o (hs_pad),
    .vsync_pad_o (vs_pad),
    .blank_pad_o (bl_pad),
    .int_o       (irq),
    .frame_cnt_o (cnt)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: whole composite computed at sample time.
  typedef struct packed {
    logic [PW-1:0] pix;
    logic          hs;
    logic          vs;
    logic          bl;
  } smp_t;

  smp_t          q[$];
  logic          mvalid = 1'b0;
  logic [PW-1:0] e_rgb;
  logic          e_hs, e_vs, e_bl, m_int, m_vp;
  logic [15:0]   m_cnt;

  function automatic logic [PW-1:0] compose();
    logic [PW-1:0] p;
    logic [PW-1:0] l;
    p = {r, g, b};
    for (int k = 0; k < NL; k++) begin
      if (lay_en[k] && lay_op[k]) begin
        l = lay_rgb[k*PW +: PW];
`ifdef DVGA_MIX_BLEND_EN
        if (blend[k]) begin
          for (int c = 0; c < 3; c++)
            p[c*CW +: CW] = CW'((int'(p[c*CW +: CW]) +
                                 int'(l[c*CW +: CW])) / 2);
        end else begin
          p = l;
        end
`else
        p = l;
`endif
      end
    end
    return p;
  endfunction

  always @(posedge clk) begin
    smp_t s;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NL + 1; i++) q.push_back('0);
      e_rgb = '0;
      {e_hs, e_vs, e_bl} = 3'b000;
      m_vp  = 1'b0;
      m_int = 1'b0;
      m_cnt = '0;
      mvalid = 1'b1;
    end else begin
      s = q.pop_front();
      e_rgb = (ctrl[0] && !s.bl) ? s.pix : '0;
      e_hs  = ctrl[0] && (ctrl[1] ^ s.hs);
      e_vs  = ctrl[0] && (ctrl[2] ^ s.vs);
      e_bl  = ctrl[0] && (ctrl[3] ^ s.bl);
      if (s.vs && !m_vp) begin
        m_int = 1'b1;
        m_cnt = m_cnt + 16'd1;
      end else if (int_clr) begin
        m_int = 1'b0;
      end
      m_vp = s.vs;
      s.pix = compose();
      s.hs  = hs;
      s.vs  = vs;
      s.bl  = bl;
      q.push_back(s);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_rgb", 64'({r_pad, g_pad, b_pad}), 64'(e_rgb));
      check("model_tim", 64'({hs_pad, vs_pad, bl_pad}),
            64'({e_hs, e_vs, e_bl}));
      check("model_int", 64'(irq), 64'(m_int));
      check("model_cnt", 64'(cnt), 64'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] exp_r;

    // Reset with busy inputs
    r = 8'hAA; g = 8'hBB; b = 8'hCC;
    hs = 1'b1; vs = 1'b1; ctrl = 4'h1;
    lay_en = '1; lay_op = '1; lay_rgb = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pads", 64'({r_pad, g_pad, b_pad,
                             hs_pad, vs_pad, bl_pad}), 64'h0);
      check("rst_int", 64'(irq), 64'h0);
      check("rst_cnt", 64'(cnt), 64'h0);
    end

    // Passthrough: latency of exactly NL+2 edges
    rst = 1'b0;
    hs = 1'b0; vs = 1'b0; bl = 1'b0;
    lay_en = '0; lay_op = '0; lay_rgb = '0;
    r = 8'h12; g = 8'h34; b = 8'h56;
    step(3);
    check("pass_early", 64'({r_pad, g_pad, b_pad}), 64'h0);
    step();
    check("pass", 64'({r_pad, g_pad, b_pad}), 64'h123456);
    bl = 1'b1;
    step(4);
    check("pass_blank", 64'({r_pad, g_pad, b_pad}), 64'h0);
    check("pass_blankpad", 64'(bl_pad), 64'h1);

    // Priority
    bl = 1'b0;
    lay_rgb = {24'h00FF00, 24'hFF0000};
    lay_en = 2'b11; lay_op = 2'b11;
    step(4);
    check("prio_top", 64'({r_pad, g_pad, b_pad}), 64'h00FF00);
    lay_op = 2'b01;
    step(4);
    check("prio_l0", 64'({r_pad, g_pad, b_pad}), 64'hFF0000);
    lay_en = 2'b10;
    step(4);
    check("prio_base", 64'({r_pad, g_pad, b_pad}), 64'h123456);
    lay_en = '0; lay_op = '0;

    // Polarity and output enable
    ctrl = 4'hF; hs = 1'b1; vs = 1'b0; bl = 1'b0;
    step(4);
    check("pol", 64'({hs_pad, vs_pad, bl_pad}), 64'b011);
    ctrl = 4'hE;
    step();
    check("outen_off", 64'({r_pad, g_pad, b_pad,
                            hs_pad, vs_pad, bl_pad}), 64'h0);

    // Frame interrupt and counter
    ctrl = 4'h1; hs = 1'b0;
    vs = 1'b1;
    step(3);
    check("irq_early", 64'({irq, cnt}), 64'h0);
    step();
    check("irq_vspad", 64'(vs_pad), 64'h1);
    check("irq_set", 64'(irq), 64'h1);
    check("irq_cnt1", 64'(cnt), 64'h1);
    vs = 1'b0;
    step(6);
    vs = 1'b1;
    step(3);
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    check("irq_setwins", 64'(irq), 64'h1);
    check("irq_cnt2", 64'(cnt), 64'h2);
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    check("irq_clr", 64'(irq), 64'h0);

    // Counter wrap
    vs = 1'b0;
    step(6);
    force dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    vs = 1'b1;
    step(4);
    check("cnt_wrap", 64'(cnt), 64'h0);
    check("cnt_wrap_irq", 64'(irq), 64'h1);

    // Changing data every cycle
    for (int i = 0; i < 16; i++) begin
      r = 8'(i * 37); g = 8'(i * 91 + 5); b = 8'(255 - i * 13);
      lay_rgb = {8'(i * 7), 8'(i * 11), 8'(i * 3),
                 8'(i * 19), 8'(i * 23), 8'(i * 29)};
      lay_en = 2'(i); lay_op = 2'(i >> 1); blend = 2'(i * 3);
      hs = i[0]; vs = i[1]; bl = (i % 7 == 3);
      ctrl = {i[2], i[3], i[0], (i % 5) != 4};
      int_clr = (i % 5 == 0);
      step();
    end
    int_clr = 1'b0; ctrl = 4'h1; blend = '0;
    step(4);

    // Blend versus replace
    vs = 1'b0; hs = 1'b0; bl = 1'b0;
    r = 8'h10; g = 8'h00; b = 8'h00;
    lay_rgb = {24'h000000, 24'h210000};
    lay_en = 2'b01; lay_op = 2'b01; blend = 2'b01;
    step(4);
`ifdef DVGA_MIX_BLEND_EN
    exp_r = 8'h18;
`else
    exp_r = 8'h21;
`endif
    check("blend_r", 64'(r_pad), 64'(exp_r));

    // Reset mid-frame
    vs = 1'b1;
    step(2);
    rst = 1'b1;
    step();
    check("midrst_pads", 64'({r_pad, g_pad, b_pad,
                              hs_pad, vs_pad, bl_pad}), 64'h0);
    check("midrst_irq", 64'({irq, cnt}), 64'h0);
    rst = 1'b0;
    step(4);
    check("rel_vs_event", 64'(cnt), 64'h1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvga_mixer.md
# dvga_mixer

Parametrised pixel compositor and pad-output stage for the dvga display controller. It takes the renderer's base pixel stream and NLAYERS independent overlay layers, such as sprites or a cursor. It composites them through a registered priority pipeline. It then drives the VGA pads with output enable and per-signal polarity control, and raises a vsync frame interrupt with a frame counter. It generalises the fixed two-sprite/pad path to N layers, configurable colour width and optional blending.

## Interface
- NLAYERS, 2: number of overlay layers, 1..8.
- CW, 8: bits per colour channel.

- clk  in  1  system clock (Wishbone clock).
- rst  in  1  reset, synchronous, active-high.
- r_i, g_i, b_i  in  CW each  base pixel from the renderer.
- hsync_i, vsync_i, blank_i  in  1 each  base timing, active-high, aligned with the base pixel.
- lay_rgb_i  in  NLAYERS*3*CW  layer k's pixel at [(k+1)*3*CW-1 : k*3*CW], packed {r,g,b}, aligned with the base pixel.
- lay_opaque_i  in  NLAYERS  layer k pixel is non-transparent.
- lay_en_i  in  NLAYERS  layer k enable.
- blend_i  in  NLAYERS  layer k blend mode; used only with DVGA_MIX_BLEND_EN.
- ctrl_i  in  4  [0] outen, [1] hsync invert, [2] vsync invert, [3] blank invert.
- int_clr_i  in  1  single-cycle clear of the frame interrupt.
- r_pad_o, g_pad_o, b_pad_o  out  CW each  registered colour pads.
- hsync_pad_o, vsync_pad_o, blank_pad_o  out  1 each  registered timing pads.
- int_o  out  1  frame interrupt pending (level).
- frame_cnt_o  out  16  frames seen since reset.

## Operation
- Input register: all pixel, timing and layer inputs (including blend_i) are sampled every cycle. There is no stall and no valid signal.
- Layer stages 0..NLAYERS-1 each hold one register. Stage k passes its incoming pixel unchanged unless lay_en[k] && lay_opaque[k]; in that case the pixel is replaced by layer k's RGB.
- Unused layer data and the timing bits travel with the pixel.
- Higher index wins: layer NLAYERS-1 is the top layer.
- Output register:
  - Colour pads = (outen && !blank) ? pixel : 0.
  - hsync_pad = outen ? (ctrl[1] ^ hsync) : 0.
  - vsync_pad = outen ? (ctrl[2] ^ vsync) : 0.
  - blank_pad = outen ? (ctrl[3] ^ blank) : 0.
- ctrl_i is applied undelayed at the output register. A change takes effect on the next edge.
- Frame event: a rising edge of the pipelined, pre-polarity vsync as it enters the output register. The previous value is kept in a dedicated register, reset to 0.
- On a frame event, int_o is set and frame_cnt_o is incremented.
  - frame_cnt_o wraps 0xFFFF -> 0x0000.
  - int_clr_i clears int_o.
  - Simultaneous frame event and clear: set wins.
- Frame events are counted regardless of outen.

## Timing
- Latency: NLAYERS+2 edges from input sample to pad. Registers are input + NLAYERS stages + output. Timing pads stay exactly aligned with colour pads.
- Throughput: one pixel per clock.
- int_o and frame_cnt_o update on the same edge that vsync_pad_o shows the rising vsync (with outen=1 and no inversion).
- Reset values:
  - All pipeline registers, pads, int_o and frame_cnt_o are 0. The vsync history register is also 0.
  - Reset asserted mid-frame: outputs go to 0 on the next edge.
  - After release, pads carry zeros until the first sampled input reaches the output NLAYERS+2 edges later.
  - A vsync that is high at reset release produces one frame event when it arrives at the output register.

## Configuration
- DVGA_MIX_BLEND_EN defined:
  - A stage with lay_en && lay_opaque && blend[k] outputs per channel (prev + layer) >> 1.
  - The sum is computed in CW+1 bits and the result floor-truncated to CW.
  - With blend[k]=0 the stage replaces the pixel.
- Macro undefined: blend_i is ignored (left unconnected internally), stages only replace, and no adder logic is generated.

## Structure
- Package dvga_mix_pkg holds:
  - ctrl bit-index constants CTRL_OUTEN=0, CTRL_HINV=1, CTRL_VINV=2, CTRL_BINV=3.
  - timing typedef struct packed {hsync, vsync, blank}.
  - the frame counter width constant FRAME_CNT_W=16.
- One sub-module, dvga_mix_stage, parameter CW: a single registered layer stage containing the select and optional blend. It is instantiated NLAYERS times in a generate loop.
- The input register, output register and interrupt/counter logic live in dvga_mixer.

## Test plan
- Reset: assert rst for 3 cycles with active inputs -> all pads 0, int_o=0, frame_cnt_o=0.
- Passthrough (NLAYERS=2, CW=8): ctrl=4'b0001, layers disabled, base {0x12,0x34,0x56}, blank=0 -> pads {0x12,0x34,0x56} exactly 4 edges later. With blank=1 -> colour pads 0.
- Priority: both layers enabled and opaque, layer0=0xFF0000, layer1=0x00FF00 -> output 0x00FF00. Same but lay_opaque[1]=0 -> 0xFF0000. Same but lay_en[0]=0 as well -> base pixel.
- Polarity/outen:
  - ctrl=4'b1111, hsync=1, vsync=0, blank=0 -> hsync_pad=0, vsync_pad=1, blank_pad=1.
  - ctrl=4'b1110 -> all pads 0 on the next edge.
- Interrupt/counter:
  - A vsync 0->1 -> int_o=1 and frame_cnt_o=1 on the edge vsync_pad rises.
  - int_clr_i coincident with the next frame event -> int_o stays 1, count=2.
  - Preload the count to 0xFFFF via 65535 frames, or force it -> the next event gives 0x0000.
- Blend (macro defined): base r=0x10, layer0 r=0x21 opaque with blend=1 -> r_pad=0x18. Same stimulus with the macro undefined -> 0x21.
